// File: rtl/menu_value_scheduler_pkg.sv
// Shared definitions for the menu value scheduler.
//   BCD_DIGITS / BCD_W : width of one published BCD field (3 digits, 12 bits)
//   DEFAULT_MAX_VAL    : largest displayable value; larger values saturate
//   state_t            : scheduler FSM states
//   add3               : digit correction step of the shift-add-3 algorithm
package menu_pkg;

  localparam int BCD_DIGITS      = 3;
  localparam int BCD_W           = 12;
  localparam int DEFAULT_MAX_VAL = 999;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    STORE = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  // A digit of 5 or more would overflow past 9 when doubled, so bias it by 3.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/menu_value_scheduler_if.sv
// Bus between the menu value scheduler and its surroundings.
//   newframe   : frame strobe, level of any length; only its rising edge counts
//   values_in  : packed field values, field i at [i*VAL_W +: VAL_W]
//   field_en   : per-field conversion enable
//   bcd_out    : packed BCD, field i at [i*12 +: 12] ({hundreds, tens, units})
//   overflow   : field saturated in its last conversion
//   busy       : a conversion pass is in progress
//   frame_done : one-cycle pulse in the final cycle of each pass
// Protocol: there is no valid/ready pair. A rising edge of newframe requests
// a pass; values_in/field_en are only sampled on the cycle the pass starts
// (or at DONE for a queued pass). busy covers the whole pass, frame_done marks
// its last cycle, and bcd_out/overflow are always whole, stable values.
interface menu_value_scheduler_if #(
  parameter int N_FIELDS = 4,
  parameter int VAL_W    = 10
);

  logic                               newframe;
  logic [N_FIELDS*VAL_W-1:0]          values_in;
  logic [N_FIELDS-1:0]                field_en;
  logic [N_FIELDS*menu_pkg::BCD_W-1:0] bcd_out;
  logic [N_FIELDS-1:0]                overflow;
  logic                               busy;
  logic                               frame_done;

  modport master (
    output newframe, values_in, field_en,
    input  bcd_out, overflow, busy, frame_done
  );

  modport slave (
    input  newframe, values_in, field_en,
    output bcd_out, overflow, busy, frame_done
  );

endinterface

// File: rtl/menu_value_scheduler_bin2bcd_iter.sv
// Iterative binary-to-BCD engine (shift-add-3), four internal digits.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture bin_in and clear the BCD accumulator
//   shift      : one correction+shift step, MSB of the binary value enters
//   bin_in     : value to convert
//   bcd        : accumulator, valid after VAL_W shift steps
module bin2bcd_iter
  import menu_pkg::*;
#(
  parameter int VAL_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [VAL_W-1:0] bin_in,
  output logic [15:0]      bcd
);

  logic [VAL_W-1:0] bin_r;
  logic [15:0]      adj;

  always_comb begin
    adj = '0;
    for (int d = 0; d < 4; d++) begin
      adj[d*4 +: 4] = add3(bcd[d*4 +: 4]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_r <= '0;
      bcd   <= '0;
    end else if (load) begin
      bin_r <= bin_in;
      bcd   <= '0;
    end else if (shift) begin
      bcd   <= {adj[14:0], bin_r[VAL_W-1]};
      bin_r <= bin_r << 1;
    end
  end

endmodule

// File: rtl/menu_value_scheduler.sv
// Per-frame scheduler that time-shares one binary-to-BCD engine across all
// menu value fields and publishes stable per-field BCD registers.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of menu_value_scheduler_if (see that file)
//   dbg_state  : current FSM state, for observation only
module menu_value_scheduler
  import menu_pkg::*;
#(
  parameter int N_FIELDS = 4,
  parameter int VAL_W    = 10,
  parameter int MAX_VAL  = DEFAULT_MAX_VAL
) (
  input  logic                   clk,
  input  logic                   rst_n,
  menu_value_scheduler_if.slave  bus,
  output state_t                 dbg_state
);

  localparam int IDX_W = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;
  localparam int CNT_W = $clog2(VAL_W + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FIELDS - 1);

  state_t                    state;
  logic                      newframe_q;
  logic                      pending;
  logic [IDX_W-1:0]          idx;
  logic [CNT_W-1:0]          cnt;
  logic                      ovf_tmp;
  logic [N_FIELDS*VAL_W-1:0] snap_vals;
  logic [N_FIELDS-1:0]       snap_en;

  logic                      start;
  logic [VAL_W-1:0]          cur_val;
  logic                      cur_ovf;
  logic [VAL_W-1:0]          eng_in;
  logic                      eng_load;
  logic                      eng_shift;
  logic [15:0]               eng_bcd;
  logic                      unused_eng_hi;

  assign start     = bus.newframe & ~newframe_q;
  assign cur_val   = snap_vals[idx*VAL_W +: VAL_W];
  assign cur_ovf   = 32'(cur_val) > MAX_VAL;
  assign eng_in    = cur_ovf ? VAL_W'(MAX_VAL) : cur_val;
  assign eng_load  = (state == LOAD) && snap_en[idx];
  assign eng_shift = (state == SHIFT);
  assign dbg_state = state;

  // Saturation keeps the value at or below 999, so the thousands digit is
  // always zero and only the low three digits are published.
  assign unused_eng_hi = ^eng_bcd[15:12];

  bin2bcd_iter #(.VAL_W(VAL_W)) u_engine (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (eng_load),
    .shift  (eng_shift),
    .bin_in (eng_in),
    .bcd    (eng_bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      newframe_q     <= 1'b0;
      pending        <= 1'b0;
      idx            <= '0;
      cnt            <= '0;
      ovf_tmp        <= 1'b0;
      snap_vals      <= '0;
      snap_en        <= '0;
      bus.bcd_out    <= '0;
      bus.overflow   <= '0;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      newframe_q     <= bus.newframe;
      bus.frame_done <= 1'b0;
      // Any start outside IDLE queues one more pass; repeats collapse.
      // DONE consumes the request itself below, overriding this set.
      if (start && state != IDLE) pending <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            snap_vals <= bus.values_in;
            snap_en   <= bus.field_en;
            idx       <= '0;
            bus.busy  <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (snap_en[idx]) begin
            ovf_tmp <= cur_ovf;
            cnt     <= '0;
            state   <= SHIFT;
          end else begin
            state   <= NEXT;
          end
        end
        SHIFT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(VAL_W - 1)) state <= STORE;
        end
        STORE: begin
          bus.bcd_out[idx*BCD_W +: BCD_W] <= eng_bcd[BCD_W-1:0];
          bus.overflow[idx]               <= ovf_tmp;
          state                           <= NEXT;
        end
        NEXT: begin
          if (idx == LAST_IDX) begin
            bus.frame_done <= 1'b1;
            state          <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= LOAD;
          end
        end
        DONE: begin
          idx <= '0;
          // A start arriving in this very cycle is served back-to-back too.
          if (pending || start) begin
            snap_vals <= bus.values_in;
            snap_en   <= bus.field_en;
            pending   <= 1'b0;
            state     <= LOAD;
          end else begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_menu_value_scheduler.sv
module tb_menu_value_scheduler;
  import menu_pkg::*;

  localparam int N  = 4;
  localparam int W  = 10;
  localparam int OW = N * BCD_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  menu_value_scheduler_if #(.N_FIELDS(N), .VAL_W(W)) bus ();
  state_t dbg_state;

  menu_value_scheduler #(.N_FIELDS(N), .VAL_W(W), .MAX_VAL(999)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [OW-1:0] exp_q[$];
  logic [11:0]   m_bcd[N];
  logic          m_ovf[N];

  typedef struct {
    logic [N*W-1:0] vals;
    logic [N-1:0]   en;
    logic [OW-1:0]  bcd;
    logic [N-1:0]   ovf;
    int             len;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pack4(input int a, input int b, input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    int s;
    s = (v > 999) ? 999 : v;
    return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_bcd[i] = '0;
      m_ovf[i] = 1'b0;
    end
  endtask

  task automatic model_apply(input logic [N*W-1:0] vals, input logic [N-1:0] en);
    int v;
    for (int i = 0; i < N; i++) begin
      v = int'(vals[i*W +: W]);
      if (en[i]) begin
        m_bcd[i] = to_bcd(v);
        m_ovf[i] = (v > 999);
      end
    end
  endtask

  function automatic logic [OW-1:0] model_bcd();
    logic [OW-1:0] r;
    for (int i = 0; i < N; i++) r[i*BCD_W +: BCD_W] = m_bcd[i];
    return r;
  endfunction

  function automatic logic [N-1:0] model_ovf();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = m_ovf[i];
    return r;
  endfunction

  function automatic int model_len(input logic [N-1:0] en);
    int l;
    l = 1;
    for (int i = 0; i < N; i++) l += en[i] ? (W + 3) : 2;
    return l;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic on_done(input string name);
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_extra_done: got frame_done with no pass expected", name);
    end else begin
      check({name, "_done_bcd"}, 64'(bus.bcd_out), 64'(exp_q.pop_front()));
    end
  endtask

  task automatic run_pass(input logic [N*W-1:0] vals, input logic [N-1:0] en,
                          input logic [OW-1:0] exp_bcd, input logic [N-1:0] exp_ovf,
                          input int exp_len, input string name);
    int busy_n, done_n;
    logic bad;
    busy_n = 0; done_n = 0; bad = 1'b0;
    exp_q.delete();
    exp_q.push_back(exp_bcd);
    bus.values_in = vals;
    bus.field_en  = en;
    bus.newframe  = 1'b1;
    for (int c = 0; c < 300; c++) begin
      tick();
      bus.newframe = 1'b0;
      for (int d = 0; d < N * BCD_DIGITS; d++)
        if (bus.bcd_out[d*4 +: 4] > 4'd9) bad = 1'b1;
      if (bus.busy) busy_n++;
      if (bus.frame_done) begin
        done_n++;
        on_done(name);
      end
      if (!bus.busy) break;
    end
    check({name, "_len"},   64'(busy_n), 64'(exp_len));
    check({name, "_dones"}, 64'(done_n), 64'd1);
    check({name, "_bcd"},   64'(bus.bcd_out), 64'(exp_bcd));
    check({name, "_ovf"},   64'(bus.overflow), 64'(exp_ovf));
    check({name, "_digits_valid"}, 64'(bad), 64'd0);
  endtask

  // mode 0: three newframe edges mid-pass; mode 1: one edge landing in DONE
  task automatic overlap_pass(input logic [N*W-1:0] va, input logic [N*W-1:0] vb,
                              input int mode, input string name);
    int busy_n, done_n;
    busy_n = 0; done_n = 0;
    exp_q.delete();
    model_apply(va, '1);
    exp_q.push_back(model_bcd());
    model_apply(vb, '1);
    exp_q.push_back(model_bcd());
    bus.values_in = va;
    bus.field_en  = '1;
    bus.newframe  = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      tick();
      bus.newframe = 1'b0;
      if (bus.busy) busy_n++;
      if (bus.frame_done) begin
        done_n++;
        on_done(name);
      end
      if (mode == 0) begin
        if (k == 5 || k == 15 || k == 25) bus.newframe = 1'b1;
        if (k == 30) bus.values_in = vb;
      end else if (bus.frame_done && done_n == 1) begin
        bus.values_in = vb;
        bus.newframe  = 1'b1;
      end
      if (!bus.busy) break;
    end
    check({name, "_len"},   64'(busy_n), 64'(2 * model_len('1)));
    check({name, "_dones"}, 64'(done_n), 64'd2);
    check({name, "_bcd"},   64'(bus.bcd_out), 64'(model_bcd()));
    check({name, "_ovf"},   64'(bus.overflow), 64'(model_ovf()));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic seen_busy, seen_done;
    logic [N*W-1:0] rv;
    logic [N-1:0]   ren;
    int             pick;

    bus.newframe  = 1'b0;
    bus.values_in = '0;
    bus.field_en  = '0;
    model_reset();

    tbl[0] = '{pack4(0, 7, 42, 999),      4'b1111, 48'h999_042_007_000, 4'b0000, 53};
    tbl[1] = '{pack4(1000, 1023, 5, 5),   4'b1111, 48'h005_005_999_999, 4'b0011, 53};
    tbl[2] = '{pack4(12, 1023, 5, 5),     4'b1111, 48'h005_005_999_012, 4'b0010, 53};
    tbl[3] = '{pack4(111, 222, 333, 444), 4'b1111, 48'h444_333_222_111, 4'b0000, 53};
    tbl[4] = '{pack4(5, 6, 7, 8),         4'b0101, 48'h444_007_222_005, 4'b0000, 31};
    tbl[5] = '{pack4(9, 9, 9, 9),         4'b0000, 48'h444_007_222_005, 4'b0000, 9};

    // Reset held with newframe toggling
    seen_busy = 1'b0; seen_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      bus.newframe = ~bus.newframe;
      tick();
      if (bus.busy) seen_busy = 1'b1;
      if (bus.frame_done) seen_done = 1'b1;
    end
    check("rst_bcd",        64'(bus.bcd_out), 64'd0);
    check("rst_ovf",        64'(bus.overflow), 64'd0);
    check("rst_busy_seen",  64'(seen_busy), 64'd0);
    check("rst_done_seen",  64'(seen_done), 64'd0);
    bus.newframe = 1'b0;
    tick();
    rst_n = 1'b1;
    seen_busy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus.busy || bus.frame_done) seen_busy = 1'b1;
    end
    check("post_rst_idle", 64'(seen_busy), 64'd0);

    // Directed table
    for (int t = 0; t < 6; t++) begin
      run_pass(tbl[t].vals, tbl[t].en, tbl[t].bcd, tbl[t].ovf, tbl[t].len,
               $sformatf("tbl%0d", t));
      model_apply(tbl[t].vals, tbl[t].en);
    end

    // Overlapping frame requests
    overlap_pass(pack4(1, 2, 3, 4), pack4(500, 600, 700, 1001), 0, "overlap3");
    overlap_pass(pack4(10, 20, 30, 40), pack4(98, 76, 54, 32), 1, "start_in_done");

    // Reset in the middle of field 2's shift phase
    bus.values_in = pack4(100, 200, 300, 400);
    bus.field_en  = '1;
    bus.newframe  = 1'b1;
    tick();
    bus.newframe = 1'b0;
    repeat (30) tick();
    check("mid_state_shift", 64'(dbg_state), 64'(SHIFT));
    check("mid_fields01",    64'(bus.bcd_out[23:0]), 64'h200_100);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_bcd",  64'(bus.bcd_out), 64'd0);
    check("async_rst_ovf",  64'(bus.overflow), 64'd0);
    check("async_rst_busy", 64'(bus.busy), 64'd0);
    check("async_rst_done", 64'(bus.frame_done), 64'd0);
    tick();
    rst_n = 1'b1;
    model_reset();
    seen_busy = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.busy || bus.frame_done) seen_busy = 1'b1;
    end
    check("after_rst_idle", 64'(seen_busy), 64'd0);
    check("after_rst_bcd",  64'(bus.bcd_out), 64'd0);
    model_apply(pack4(100, 200, 300, 400), '1);
    run_pass(pack4(100, 200, 300, 400), '1, model_bcd(), model_ovf(), model_len('1), "post_rst_pass");

    // Randomized passes against the reference model
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < N; i++) begin
        pick = $urandom_range(0, 5);
        case (pick)
          0: rv[i*W +: W] = W'(0);
          1: rv[i*W +: W] = W'(999);
          2: rv[i*W +: W] = W'($urandom_range(1000, 1023));
          default: rv[i*W +: W] = W'($urandom_range(0, 1023));
        endcase
      end
      ren = N'($urandom_range(0, (1 << N) - 1));
      model_apply(rv, ren);
      run_pass(rv, ren, model_bcd(), model_ovf(), model_len(ren), $sformatf("rand%0d", r));
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/menu_value_scheduler.md
Name: menu_value_scheduler

Overview:
- Per-frame controller that converts the binary values of all numeric menu fields to 3-digit BCD for the on-screen character generator.
- Owns one iterative binary-to-BCD engine (shift-add-3) and time-shares it across N_FIELDS requesters, one after another.
- Starts on each rising edge of newframe. Publishes stable per-field BCD registers for the character-address ROM stage.

Parameters:
- N_FIELDS, 4, number of menu value fields serviced per frame (1..16)
- VAL_W, 10, binary width of each field value
- MAX_VAL, 999, largest displayable value; larger values saturate

Ports:
- clk  input  1  system pixel/logic clock
- rst_n  input  1  asynchronous active-low reset
- newframe  input  1  frame strobe, synchronous to clk, level of any length; only its rising edge is used
- values_in  input  N_FIELDS*VAL_W  packed field values; field i occupies [i*VAL_W +: VAL_W]
- field_en  input  N_FIELDS  per-field conversion enable
- bcd_out  output  N_FIELDS*12  packed BCD per field: [11:8] hundreds, [7:4] tens, [3:0] units
- overflow  output  N_FIELDS  field value exceeded MAX_VAL in its last conversion
- busy  output  1  high while a conversion pass is in progress
- frame_done  output  1  one-cycle pulse at the end of each pass

Behaviour:
- Reset is asynchronous, active-low, on clk. On reset:
  - bcd_out = 0, overflow = 0, busy = 0, frame_done = 0
  - FSM = IDLE, pending = 0, field index = 0, snapshot regs = 0
- Reset asserted mid-pass aborts the pass immediately. No partial store completes.
- Edge detect: newframe is registered once. start = newframe & ~newframe_q.
- On start in IDLE:
  - values_in and field_en are snapshotted into internal registers.
  - All later work uses only the snapshot, so one pass is frame-consistent.
- FSM states: IDLE, LOAD, SHIFT, STORE, NEXT, DONE.
  - IDLE -> LOAD on start. busy rises in the same cycle LOAD is entered.
  - LOAD (1 cycle):
    - If snapshot field_en[idx] = 0, go to NEXT. bcd_out and overflow for that field are unchanged.
    - Otherwise load the engine with the value. If value > MAX_VAL, load MAX_VAL and set ovf_tmp = 1.
    - Go to SHIFT.
  - SHIFT (exactly VAL_W cycles): each cycle, add 3 to every BCD digit >= 5, then shift left 1 with the next binary MSB entering.
  - STORE (1 cycle): write the 12-bit result to bcd_out field idx and write ovf_tmp to overflow[idx].
  - NEXT (1 cycle):
    - If idx = N_FIELDS-1, go to DONE.
    - Otherwise idx <= idx+1 and go to LOAD.
  - DONE (1 cycle):
    - frame_done = 1, idx <= 0.
    - If pending, take a new snapshot, clear pending and go to LOAD (busy stays high).
    - Else go to IDLE and busy <= 0.
- Latency:
  - Enabled field: VAL_W+3 cycles (13 at default).
  - Disabled field: 2 cycles.
  - Full pass with all fields enabled: N_FIELDS*(VAL_W+3)+1 cycles from the LOAD entry. Default: 53.
- Boundary conditions:
  - start while busy sets pending. Further starts while pending is already set are collapsed, so at most one pass is queued.
  - start in the same cycle as DONE counts as pending and is served back-to-back.
  - bcd_out field i changes only in its STORE cycle. Readers may sample at any time and always get a complete, valid BCD triple.
  - Value exactly 999 gives 0x999 with overflow = 0. Value 1000 gives 0x999 with overflow = 1. Value 1023 gives 0x999 with overflow = 1.
  - Value 0 gives 0x000.
  - field_en all zero: pass takes 2*N_FIELDS+1 cycles and frame_done still pulses.

Decomposition:
- Shared package menu_pkg holds:
  - BCD_DIGITS = 3, BCD_W = 12
  - the FSM state enum type
  - the MAX_VAL default
- One sub-module, bin2bcd_iter: the load/shift-add-3 engine.
  - Ports: clk, rst_n, load, shift, bin_in[VAL_W], bcd[15:0].
  - Carries 4 digits internally. The scheduler uses the low 12 bits after saturation.

Test Plan:
- Reset: hold rst_n = 0 with newframe toggling -> all outputs 0, no frame_done. Release -> still idle until the next newframe rising edge.
- Basic pass: values {0, 7, 42, 999}, field_en = 4'b1111, one newframe edge.
  - busy for 53 cycles, then a single frame_done pulse.
  - bcd_out = {0x999, 0x042, 0x007, 0x000}, overflow = 0.
- Saturation: field0 = 1000, field1 = 1023, others = 5.
  - field0 and field1 show 0x999 with overflow bits set; others show 0x005.
  - A later pass with field0 = 12 -> 0x012 and overflow[0] cleared.
- Disabled field: pass1 values {111, 222, 333, 444}, all enabled. Pass2 values {5, 6, 7, 8}, field_en = 4'b0101.
  - Result: fields 0 and 2 = 0x005 and 0x007; fields 1 and 3 keep 0x222 and 0x444.
  - Pass2 length = 13+2+13+2+1 = 31 cycles.
- Overlapping frames: three newframe edges during one busy pass.
  - Exactly one extra pass runs back-to-back, with busy held high across it.
  - Two frame_done pulses in total. The second pass uses values_in sampled at the first DONE.
- Reset mid-SHIFT of field 2: assert rst_n = 0.
  - All outputs clear asynchronously. After release, nothing happens until the next newframe edge, which runs a normal full pass.
